// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall handling
// and a saturating count of inserted bubbles.
module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic               id_regdst,
  input  logic               id_alusrc,
  input  logic               id_memtoreg,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_branch,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [DATA_W-1:0]  id_readda1,
  input  logic [DATA_W-1:0]  id_readda2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [RA_W-1:0]    id_rs,
  input  logic [RA_W-1:0]    id_rt,
  input  logic [RA_W-1:0]    id_rd,
  input  logic               stall,
  input  logic               flush,
  output logic               ex_valid,
  output logic               ex_regdst,
  output logic               ex_alusrc,
  output logic               ex_memtoreg,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_branch,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [DATA_W-1:0]  ex_readda1,
  output logic [DATA_W-1:0]  ex_readda2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [RA_W-1:0]    ex_rs,
  output logic [RA_W-1:0]    ex_rt,
  output logic [RA_W-1:0]    ex_rd,
  output logic               load_use_stall,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam int CTRL_W = 7;

  logic               valid_q, valid_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic [DATA_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  rda1_q, rda1_d;
  logic [DATA_W-1:0]  rda2_q, rda2_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [RA_W-1:0]    rs_q, rs_d;
  logic [RA_W-1:0]    rt_q, rt_d;
  logic [RA_W-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [CTRL_W-1:0]  id_ctrl;
  logic               ex_memread_q;
  logic               bubble;

  assign id_ctrl = {id_regdst, id_alusrc, id_memtoreg, id_regwrite,
                    id_memread, id_memwrite, id_branch};
  assign ex_memread_q = ctrl_q[2];

  // $0 is hardwired, so a load targeting it can never create a real hazard
  assign load_use_stall = valid_q & ex_memread_q & id_valid & (rt_q != '0) &
                          ((rt_q == id_rs) | (rt_q == id_rt)) & ~stall & ~flush;

  assign bubble = flush | load_use_stall;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    aluop_d = aluop_q;
    pc_d    = pc_q;
    rda1_d  = rda1_q;
    rda2_d  = rda2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (bubble) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      aluop_d = '0;
      pc_d    = '0;
      rda1_d  = '0;
      rda2_d  = '0;
      imm_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      if (id_valid && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!stall) begin
      // an empty slot must never carry write enables into later stages
      valid_d = id_valid;
      ctrl_d  = id_valid ? id_ctrl : '0;
      aluop_d = id_valid ? id_aluop : '0;
      pc_d    = id_pc;
      rda1_d  = id_readda1;
      rda2_d  = id_readda2;
      imm_d   = id_imm;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      aluop_q <= '0;
      pc_q    <= '0;
      rda1_q  <= '0;
      rda2_q  <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      aluop_q <= aluop_d;
      pc_q    <= pc_d;
      rda1_q  <= rda1_d;
      rda2_q  <= rda2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid = valid_q;
  assign {ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite,
          ex_memread, ex_memwrite, ex_branch} = ctrl_q;
  assign ex_aluop   = aluop_q;
  assign ex_pc      = pc_q;
  assign ex_readda1 = rda1_q;
  assign ex_readda2 = rda2_q;
  assign ex_imm     = imm_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign bubble_cnt = cnt_q;

endmodule
